dequeue_reassembler: RTL



---
 rtl/dequeue_reassembler_if.sv | 30 +++
 rtl/dequeue_reassembler.sv | 109 ++++++++++
 2 files changed

// File: rtl/dequeue_reassembler_if.sv
// Stream bundle for dequeue_reassembler: block input side and reassembled-word output side.
// master drives blocks and ready_i; slave is the reassembler.
interface dequeue_reassembler_if #(
    parameter int BlockSize = 9,
    parameter int NumBlocks = 4
);
    localparam int CntW  = $clog2(NumBlocks + 1);
    localparam int DataW = NumBlocks * (BlockSize - 1);

    logic                 valid_i;
    logic                 ready_o;
    logic [BlockSize-1:0] block_i;
    logic [CntW-1:0]      num_blocks_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [DataW-1:0]     data_o;
    logic [CntW-1:0]      num_blocks_o;
    logic                 err_o;
    logic [15:0]          err_cnt_o;

    modport master (
        output valid_i, block_i, num_blocks_i, ready_i,
        input  ready_o, valid_o, data_o, num_blocks_o, err_o, err_cnt_o
    );

    modport slave (
        input  valid_i, block_i, num_blocks_i, ready_i,
        output ready_o, valid_o, data_o, num_blocks_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/dequeue_reassembler.sv
// Strips start markers from incoming blocks and reassembles one packet per output word.
// Optional macro SERIAL_LINK_DEQUEUE_ERR_CNT_EN enables a saturating framing-error counter.
module dequeue_reassembler #(
    parameter int BlockSize = 9,
    parameter int NumBlocks = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dequeue_reassembler_if.slave  bus
);
    localparam int CntW  = $clog2(NumBlocks + 1);
    localparam int PW    = BlockSize - 1;
    localparam int DataW = NumBlocks * PW;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL
    } state_e;

    state_e           state_q;
    logic [DataW-1:0] data_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  exp_q;
    logic             err_q;

    logic             fire;
    logic             start;
    logic [PW-1:0]    payload;
    logic [CntW-1:0]  exp_eff;
    logic [CntW-1:0]  cnt_inc;

    assign fire    = bus.valid_i && bus.ready_o;
    assign start   = bus.block_i[0];
    assign payload = bus.block_i[BlockSize-1:1];
    assign cnt_inc = cnt_q + CntW'(1);

    // Out-of-range or zero counts mean a full-length packet
    always_comb begin
        exp_eff = bus.num_blocks_i;
        if (bus.num_blocks_i == '0 || bus.num_blocks_i > CntW'(NumBlocks))
            exp_eff = CntW'(NumBlocks);
    end

    // Packet FSM with the data, count and error registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE, COLLECT: begin
                    if (fire) begin
                        if (start) begin
                            // A start mid-packet abandons the partial one
                            if (state_q == COLLECT)
                                err_q <= 1'b1;
                            data_q  <= DataW'(payload);
                            cnt_q   <= CntW'(1);
                            exp_q   <= exp_eff;
                            state_q <= (exp_eff == CntW'(1)) ? FULL : COLLECT;
                        end else if (state_q == IDLE) begin
                            err_q <= 1'b1;
                        end else begin
                            for (int k = 0; k < NumBlocks; k++)
                                if (CntW'(k) == cnt_q)
                                    data_q[k*PW +: PW] <= payload;
                            cnt_q <= cnt_inc;
                            if (cnt_inc == exp_q)
                                state_q <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (bus.ready_i)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready_o      = (state_q != FULL);
    assign bus.valid_o      = (state_q == FULL);
    assign bus.data_o       = data_q;
    assign bus.num_blocks_o = cnt_q;
    assign bus.err_o        = err_q;

`ifdef SERIAL_LINK_DEQUEUE_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of framing-error pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_cnt_q <= '0;
        else if (err_q && err_cnt_q != 16'hFFFF)
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign bus.err_cnt_o = err_cnt_q;
`else
    assign bus.err_cnt_o = '0;
`endif

endmodule
